sap1_control_sequencer: RTL and testbench
=========================================

// Module: sap1_control_sequencer
// PURPOSE
//  Microcoded control sequencer for the 8-bit SAP-1 datapath. It steps through
//  fetch and execute T-states and drives the one-hot control lines for
//  PC, MAR, RAM, IR, A, B, OUT and the ALU (alu_en, alu_sub, alu_fi).
//  It consumes the ALU's latched carry/zero for conditional jumps.
//  Sits between the instruction register (opcode in) and every datapath enable.
// PARAMETERS
//  OP_WIDTH  4  opcode width; only 4 is supported (elaboration error otherwise)
//  STEP_W    3  width of the T-state counter; holds T0..T4
// PORTS
//  clk       in   1         system clock, all state on rising edge
//  rst       in   1         synchronous, active-high reset
//  opcode    in   OP_WIDTH  IR upper nibble; must be valid from T2 to end of instr
//  carry     in   1         ALU carry flag (latched by ALU on alu_fi)
//  zero      in   1         ALU zero flag (latched by ALU on alu_fi)
//  pc_out, pc_inc, pc_load      out 1  CO / CE / J
//  mar_in, ram_out, ram_in      out 1  MI / RO / RI
//  ir_in, ir_out                out 1  II / IO (IO drives the operand nibble)
//  a_in, a_out, b_in, out_in    out 1  AI / AO / BI / OI
//  alu_en, alu_sub, alu_fi      out 1  EO / SU / FI to the ALU
//  halt      out  1         HLT; stays high in HALTED
//  step      out  STEP_W    current T-state (debug)
// BEHAVIOUR
//  - State: step counter 0..4 plus halted bit. Controls are decoded from state.
//    They are combinational (Moore), except pc_load for JC/JZ, which also
//    depends on carry/zero.
//  - Reset: step=0, halted=0. While rst=1 every control output is forced to 0.
//  - T0: pc_out, mar_in.  T1: ram_out, ir_in, pc_inc.  These are always fetched.
//  - Execute (the last listed step returns step to 0 on the next edge):
//    0000 NOP: T2 no controls (last).
//    0001 LDA: T2 ir_out,mar_in; T3 ram_out,a_in (last).
//    0010 ADD: T2 ir_out,mar_in; T3 ram_out,b_in; T4 alu_en,a_in,alu_fi (last).
//    0011 SUB: ADD, with alu_sub=1 in T4 only.
//    0100 STA: T2 ir_out,mar_in; T3 a_out,ram_in (last).
//    0101 LDI: T2 ir_out,a_in (last).
//    0110 JMP: T2 ir_out,pc_load (last).
//    0111 JC:  T2 ir_out, pc_load=carry (last).
//    1000 JZ:  T2 ir_out, pc_load=zero (last).
//    1110 OUT: T2 a_out,out_in (last).
//    1111 HLT: T2 halt; the next edge sets halted.
//    Any other opcode executes as NOP.
//  - Instruction lengths: 3 cycles for NOP, LDI, JMP, JC, JZ and OUT.
//    4 cycles for LDA and STA. 5 cycles for ADD and SUB.
//  - alu_sub is never high outside SUB T4. alu_fi is asserted only in ADD/SUB T4.
//  - HALTED: step holds at 2 and halt=1. All other controls are 0.
//    Only rst leaves HALTED.
//  - At most one of pc_out, ram_out, ir_out, a_out, alu_en is high in any cycle
//    (bus exclusivity). A bench assertion checks this.
//  - A rst asserted in any step, including mid-ADD or in HALTED, returns to T0
//    on the next edge. No partial control is emitted in the reset cycle.
//  - step never exceeds 4. An illegal step value decodes to no controls and
//    returns to 0.
// TESTING
//  1. rst 2 cycles, opcode=0001 (LDA): T0 pc_out+mar_in, T1 ram_out+ir_in+pc_inc,
//     T2 ir_out+mar_in, T3 ram_out+a_in, then step=0.
//  2. opcode=0011 (SUB): T4 shows alu_en=alu_sub=alu_fi=a_in=1.
//     No alu_sub in T0..T3. The next fetch starts 5 cycles after the previous one.
//  3. opcode=0111 with carry=0: no pc_load in T2. Repeat with carry=1: pc_load=1.
//     Same check for 1000 with zero=0/1.
//  4. opcode=1111: halt=1 from T2 on, for 20+ cycles, with step=2 and no other
//     controls. Then rst -> step=0, halt=0.
//  5. rst pulsed during ADD T3: all outputs are 0 in the reset cycle and the
//     next cycle is T0.
//  6. opcodes 1001..1101: behave as NOP (3 cycles, no controls in T2).
//     Random opcode stream: bus-exclusivity assertion never fires.

Source files
------------

// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: fetch/execute T-state counter with a halted bit.
// All control lines are decoded combinationally from the current state.
module sap1_control_sequencer #(
   parameter int OP_WIDTH = 4,
   parameter int STEP_W   = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OP_WIDTH-1:0] opcode,
   input  logic                carry,
   input  logic                zero,
   output logic                pc_out,
   output logic                pc_inc,
   output logic                pc_load,
   output logic                mar_in,
   output logic                ram_out,
   output logic                ram_in,
   output logic                ir_in,
   output logic                ir_out,
   output logic                a_in,
   output logic                a_out,
   output logic                b_in,
   output logic                out_in,
   output logic                alu_en,
   output logic                alu_sub,
   output logic                alu_fi,
   output logic                halt,
   output logic [STEP_W-1:0]   step
);

   // state   | meaning
   // T0      | fetch: PC onto bus, latch MAR
   // T1      | fetch: RAM into IR, increment PC
   // T2..T4  | execute micro-steps of the current opcode
   // halted  | HLT retired; step parked at T2, only rst leaves
   typedef enum logic [STEP_W-1:0] {
      T0 = STEP_W'(0),
      T1 = STEP_W'(1),
      T2 = STEP_W'(2),
      T3 = STEP_W'(3),
      T4 = STEP_W'(4)
   } step_t;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   generate
      if (OP_WIDTH != 4) begin : g_bad_op_width
         $error("sap1_control_sequencer: OP_WIDTH must be 4");
      end
      if (STEP_W < 3) begin : g_bad_step_w
         $error("sap1_control_sequencer: STEP_W must be at least 3");
      end
   endgenerate

   step_t      step_q, step_d;
   logic       halted_q, halted_d;
   logic [3:0] op;
   logic       long_op;
   logic       alu_op;

   assign op      = opcode[3:0];
   assign alu_op  = (op == OP_ADD) || (op == OP_SUB);
   assign long_op = alu_op || (op == OP_LDA) || (op == OP_STA);

   always_ff @(posedge clk) begin
      if (rst) begin
         step_q   <= T0;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      step_d   = T0;
      halted_d = halted_q;
      if (halted_q) begin
         step_d = step_q;
      end else begin
         unique case (step_q)
            T0: step_d = T1;
            T1: step_d = T2;
            T2: begin
               if (op == OP_HLT) begin
                  step_d   = T2;
                  halted_d = 1'b1;
               end else if (long_op) begin
                  step_d = T3;
               end else begin
                  step_d = T0;
               end
            end
            T3: step_d = alu_op ? T4 : T0;
            default: step_d = T0;
         endcase
      end
   end

   always_comb begin
      pc_out  = 1'b0;
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      mar_in  = 1'b0;
      ram_out = 1'b0;
      ram_in  = 1'b0;
      ir_in   = 1'b0;
      ir_out  = 1'b0;
      a_in    = 1'b0;
      a_out   = 1'b0;
      b_in    = 1'b0;
      out_in  = 1'b0;
      alu_en  = 1'b0;
      alu_sub = 1'b0;
      alu_fi  = 1'b0;
      halt    = 1'b0;
      step    = step_q;
      // Reset masks every output, including the debug step view.
      if (rst) begin
         step = '0;
      end else if (halted_q) begin
         halt = 1'b1;
      end else begin
         case (step_q)
            T0: begin
               pc_out = 1'b1;
               mar_in = 1'b1;
            end
            T1: begin
               ram_out = 1'b1;
               ir_in   = 1'b1;
               pc_inc  = 1'b1;
            end
            T2: begin
               case (op)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     ir_out = 1'b1;
                     mar_in = 1'b1;
                  end
                  OP_LDI: begin
                     ir_out = 1'b1;
                     a_in   = 1'b1;
                  end
                  OP_JMP: begin
                     ir_out  = 1'b1;
                     pc_load = 1'b1;
                  end
                  OP_JC: begin
                     ir_out  = 1'b1;
                     pc_load = carry;
                  end
                  OP_JZ: begin
                     ir_out  = 1'b1;
                     pc_load = zero;
                  end
                  OP_OUT: begin
                     a_out  = 1'b1;
                     out_in = 1'b1;
                  end
                  OP_HLT: halt = 1'b1;
                  default: ;
               endcase
            end
            T3: begin
               case (op)
                  OP_LDA: begin
                     ram_out = 1'b1;
                     a_in    = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     ram_out = 1'b1;
                     b_in    = 1'b1;
                  end
                  OP_STA: begin
                     a_out  = 1'b1;
                     ram_in = 1'b1;
                  end
                  default: ;
               endcase
            end
            T4: begin
               if (alu_op) begin
                  alu_en  = 1'b1;
                  a_in    = 1'b1;
                  alu_fi  = 1'b1;
                  alu_sub = (op == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Directed and randomized checks of the SAP-1 sequencer against an
// instruction-level model (micro-op table plus instruction lengths).
module tb_sap1_control_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] opcode;
   logic       carry, zero;
   logic       pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out;
   logic       a_in, a_out, b_in, out_in, alu_en, alu_sub, alu_fi, halt;
   logic [2:0] step;

   int checks = 0;
   int errors = 0;
   string tag = "init";

   int m_t = 0;
   bit m_halted = 1'b0;

   localparam logic [14:0] CO = 15'h4000, CE = 15'h2000, J  = 15'h1000;
   localparam logic [14:0] MI = 15'h0800, RO = 15'h0400, RI = 15'h0200;
   localparam logic [14:0] II = 15'h0100, IO = 15'h0080, AI = 15'h0040;
   localparam logic [14:0] AO = 15'h0020, BI = 15'h0010, OI = 15'h0008;
   localparam logic [14:0] EO = 15'h0004, SU = 15'h0002, FI = 15'h0001;

   always #5 clk = ~clk;

   sap1_control_sequencer #(.OP_WIDTH(4), .STEP_W(3)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .carry(carry), .zero(zero),
      .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_in(mar_in),
      .ram_out(ram_out), .ram_in(ram_in), .ir_in(ir_in), .ir_out(ir_out),
      .a_in(a_in), .a_out(a_out), .b_in(b_in), .out_in(out_in),
      .alu_en(alu_en), .alu_sub(alu_sub), .alu_fi(alu_fi),
      .halt(halt), .step(step)
   );

   // Instruction length in cycles, fetch included; HLT never completes.
   function automatic int instr_len(input logic [3:0] op);
      case (op)
         4'h1, 4'h4: return 4;
         4'h2, 4'h3: return 5;
         default:    return 3;
      endcase
   endfunction

   // Micro-op table: execute step k (0 = T2) of opcode op.
   function automatic logic [14:0] exec_ops(input logic [3:0] op, input int k,
                                            input logic c, input logic z);
      logic [14:0] lda[3], add[3], sub[3], sta[3];
      lda = '{IO | MI, RO | AI, 15'h0};
      add = '{IO | MI, RO | BI, EO | AI | FI};
      sub = '{IO | MI, RO | BI, EO | AI | FI | SU};
      sta = '{IO | MI, AO | RI, 15'h0};
      if (k < 0 || k > 2) return 15'h0;
      case (op)
         4'h1: return lda[k];
         4'h2: return add[k];
         4'h3: return sub[k];
         4'h4: return sta[k];
         4'h5: return (k == 0) ? (IO | AI) : 15'h0;
         4'h6: return (k == 0) ? (IO | J) : 15'h0;
         4'h7: return (k == 0) ? (IO | (c ? J : 15'h0)) : 15'h0;
         4'h8: return (k == 0) ? (IO | (z ? J : 15'h0)) : 15'h0;
         4'hE: return (k == 0) ? (AO | OI) : 15'h0;
         default: return 15'h0;
      endcase
   endfunction

   function automatic logic [18:0] model_out();
      logic [14:0] ctl;
      logic        h;
      logic [2:0]  s;
      ctl = 15'h0; h = 1'b0; s = 3'(m_t);
      if (rst) begin
         s = 3'd0;
      end else if (m_halted) begin
         h = 1'b1;
         s = 3'd2;
      end else if (m_t == 0) begin
         ctl = CO | MI;
      end else if (m_t == 1) begin
         ctl = RO | II | CE;
      end else begin
         ctl = exec_ops(opcode, m_t - 2, carry, zero);
         h = (m_t == 2) && (opcode == 4'hF);
      end
      return {ctl, h, s};
   endfunction

   // Compare one cycle, then clock it and advance the model.
   task automatic cycle();
      logic [18:0] act, exp;
      #1;
      act = {pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
             a_in, a_out, b_in, out_in, alu_en, alu_sub, alu_fi, halt, step};
      exp = model_out();
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s t=%0d observed=%b expected=%b", tag, m_t, act, exp);
      end
      checks++;
      assert ($onehot0({pc_out, ram_out, ir_out, a_out, alu_en})) else begin
         errors++;
         $error("FAIL bus_excl %s observed=%b expected=onehot0", tag,
                {pc_out, ram_out, ir_out, a_out, alu_en});
      end
      @(posedge clk);
      if (rst) begin
         m_t = 0;
         m_halted = 1'b0;
      end else if (!m_halted) begin
         if (m_t == 2 && opcode == 4'hF) m_halted = 1'b1;
         else if (m_t == instr_len(opcode) - 1) m_t = 0;
         else m_t++;
      end
      #1;
   endtask

   task automatic run_instr(input logic [3:0] op, input string name);
      tag = name;
      opcode = op;
      for (int i = 0; i < instr_len(op); i++) cycle();
   endtask

   initial begin
      rst = 1'b1; opcode = 4'h1; carry = 1'b0; zero = 1'b0;
      tag = "reset";
      cycle();
      cycle();
      rst = 1'b0;

      run_instr(4'h1, "lda");
      run_instr(4'h3, "sub");
      run_instr(4'h3, "sub2");
      run_instr(4'h2, "add");
      run_instr(4'h4, "sta");

      carry = 1'b0; run_instr(4'h7, "jc_c0");
      carry = 1'b1; run_instr(4'h7, "jc_c1");
      zero  = 1'b0; run_instr(4'h8, "jz_z0");
      zero  = 1'b1; run_instr(4'h8, "jz_z1");
      run_instr(4'h6, "jmp");
      run_instr(4'h5, "ldi");
      run_instr(4'hE, "out");
      run_instr(4'h0, "nop");

      tag = "hlt"; opcode = 4'hF;
      for (int i = 0; i < 25; i++) begin
         if (i == 10) opcode = 4'h2;
         cycle();
      end
      tag = "hlt_rst"; rst = 1'b1; cycle(); rst = 1'b0;
      run_instr(4'h5, "after_hlt");

      tag = "add_rst"; opcode = 4'h2;
      cycle(); cycle(); cycle();
      rst = 1'b1; cycle(); rst = 1'b0;
      tag = "add_rst_t0";
      cycle(); cycle();
      run_instr(4'h2, "add_resync");

      for (int op = 9; op <= 13; op++) run_instr(4'(op), "illegal_nop");

      tag = "random";
      begin
         int halt_cnt;
         halt_cnt = 0;
         for (int i = 0; i < 600; i++) begin
            carry = 1'($urandom);
            zero  = 1'($urandom);
            if (m_t == 0 && !m_halted) opcode = 4'($urandom);
            halt_cnt = m_halted ? halt_cnt + 1 : 0;
            rst = ($urandom_range(0, 39) == 0) || (halt_cnt > 6);
            cycle();
         end
         rst = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
